// File: rtl/pulse_compression_sequencer_pkg.sv
// Shared types and width constants for the pulse compression sequencer.
package pulse_compression_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_COEFF,
      STREAM,
      FLUSH,
      GAP,
      DONE,
      ERROR
   } pcs_state_t;

   localparam int OUT_INDEX_W   = 16;
   localparam int PULSE_INDEX_W = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed for a down-counter loaded with max_count-1.
   function automatic int cnt_width(input int max_count);
      return (max_count > 1) ? $clog2(max_count) : 1;
   endfunction

endpackage

// File: rtl/pulse_compression_sequencer_if.sv
// Control/status bundle between radar timing logic (master) and the sequencer (slave).
interface pulse_compression_sequencer_if;
   import pulse_compression_pkg::*;

   logic                     start;
   logic                     abort;
   logic [PULSE_INDEX_W-1:0] numPulses;
   logic                     coeffSetFlag;
`ifdef PCS_RANGE_GATE_EN
   logic [OUT_INDEX_W-1:0]   gateStart;
   logic [OUT_INDEX_W-1:0]   gateEnd;
`endif
   logic                     enableMFCoeff;
   logic                     loadCoeff;
   logic                     enableMFDataIn;
   logic                     enableHT;
   logic                     loadDataFlag;
   logic                     stopDataLoadFlag;
   logic                     enableSquar;
   logic                     outValid;
   logic [OUT_INDEX_W-1:0]   outIndex;
   logic [PULSE_INDEX_W-1:0] pulseIndex;
   logic                     busy;
   logic                     done;
   logic                     error;

   modport master (
      output start, abort, numPulses, coeffSetFlag,
`ifdef PCS_RANGE_GATE_EN
      output gateStart, gateEnd,
`endif
      input  enableMFCoeff, loadCoeff, enableMFDataIn, enableHT, loadDataFlag,
      input  stopDataLoadFlag, enableSquar, outValid, outIndex, pulseIndex,
      input  busy, done, error
   );

   modport slave (
      input  start, abort, numPulses, coeffSetFlag,
`ifdef PCS_RANGE_GATE_EN
      input  gateStart, gateEnd,
`endif
      output enableMFCoeff, loadCoeff, enableMFDataIn, enableHT, loadDataFlag,
      output stopDataLoadFlag, enableSquar, outValid, outIndex, pulseIndex,
      output busy, done, error
   );

endinterface

// File: rtl/pcs_valid_window.sv
// Delays a stream-start strobe by PIPE_LATENCY cycles, then opens a valid window of WINDOW_LENGTH cycles.
module pcs_valid_window
   import pulse_compression_pkg::*;
#(
   parameter int PIPE_LATENCY  = 30,
   parameter int WINDOW_LENGTH = 8499
) (
   input  logic                   clock,
   input  logic                   resetN,
   input  logic                   i_start,
   input  logic                   i_clear,
   output logic                   o_valid,
   output logic [OUT_INDEX_W-1:0] o_index
);

   localparam int DLY_W = cnt_width(PIPE_LATENCY);

   logic                   r_wait;
   logic [DLY_W-1:0]       r_dly;
   logic                   r_valid;
   logic [OUT_INDEX_W-1:0] r_index;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_wait  <= 1'b0;
         r_dly   <= '0;
         r_valid <= 1'b0;
         r_index <= '0;
      end else if (i_clear) begin
         r_wait  <= 1'b0;
         r_dly   <= '0;
         r_valid <= 1'b0;
         r_index <= '0;
      end else begin
         if (i_start) begin
            r_wait <= 1'b1;
            r_dly  <= DLY_W'(PIPE_LATENCY - 1);
         end else if (r_wait) begin
            if (r_dly == '0) begin
               r_wait  <= 1'b0;
               r_valid <= 1'b1;
               r_index <= '0;
            end else begin
               r_dly <= r_dly - 1'b1;
            end
         end
         if (r_valid) begin
            if (r_index == OUT_INDEX_W'(WINDOW_LENGTH - 1)) begin
               r_valid <= 1'b0;
               r_index <= '0;
            end else begin
               r_index <= r_index + 1'b1;
            end
         end
      end
   end

   assign o_valid = r_valid;
   assign o_index = r_index;

endmodule

// File: rtl/pulse_compression_sequencer.sv
// Pulse compression control FSM: coefficient load, per-pulse stream/flush/gap, valid window.
// Optional range gating of outValid when PCS_RANGE_GATE_EN is defined.
//
// state      | meaning
// IDLE       | waiting for start, all enables low
// LOAD_COEFF | coefficient reader + FIR coeff load, timeout running
// STREAM     | DATA_LENGTH samples into Hilbert/FIR/magnitude
// FLUSH      | FIR drained for COEFF_LENGTH+PIPE_LATENCY cycles
// GAP        | idle spacing between pulses
// DONE       | one-cycle run completion
// ERROR      | coefficient timeout, back to IDLE next cycle
module pulse_compression_sequencer
   import pulse_compression_pkg::*;
#(
   parameter int COEFF_LENGTH  = 800,
   parameter int DATA_LENGTH   = 7700,
   parameter int PIPE_LATENCY  = 30,
   parameter int GAP_CYCLES    = 16,
   parameter int COEFF_TIMEOUT = 2048
) (
   input  logic                         clock,
   input  logic                         resetN,
   pulse_compression_sequencer_if.slave bus
);

   localparam int FLUSH_CYCLES = COEFF_LENGTH + PIPE_LATENCY;
   localparam int TMR_MAX      = max_int(max_int(COEFF_TIMEOUT, DATA_LENGTH),
                                         max_int(FLUSH_CYCLES, GAP_CYCLES));
   localparam int TMR_W        = cnt_width(TMR_MAX);

   pcs_state_t               r_state;
   pcs_state_t               w_state_next;
   logic [TMR_W-1:0]         r_tmr;
   logic [TMR_W-1:0]         w_tmr_next;
   logic                     w_tmr_zero;
   logic [PULSE_INDEX_W-1:0] r_pulse_idx;
   logic [PULSE_INDEX_W-1:0] w_pulse_inc;
   logic [PULSE_INDEX_W-1:0] r_num_pulses;
   logic                     r_error;
   logic                     w_accept;
   logic                     w_err_enter;
   logic                     w_flush_end;
   logic                     w_last_pulse;
   logic                     w_stream_start;
   logic                     w_en_coeff;
   logic                     w_en_data;
   logic                     w_en_ht;
   logic                     w_load_data;
   logic                     w_stop_load;
   logic                     w_en_squar;
   logic                     w_done;
   logic                     w_win_valid;
   logic [OUT_INDEX_W-1:0]   w_win_index;

   assign w_tmr_zero   = (r_tmr == '0);
   assign w_pulse_inc  = r_pulse_idx + 1'b1;
   assign w_last_pulse = (r_num_pulses != '0) && (w_pulse_inc == r_num_pulses);
   assign w_accept     = (r_state == IDLE) && bus.start && !bus.abort;
   assign w_err_enter  = (r_state == LOAD_COEFF) && (w_state_next == ERROR);
   assign w_flush_end  = (r_state == FLUSH) && w_tmr_zero && !bus.abort;
   assign w_stream_start = (w_state_next == STREAM) && (r_state != STREAM);

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_state      <= IDLE;
         r_tmr        <= '0;
         r_pulse_idx  <= '0;
         r_num_pulses <= '0;
         r_error      <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_tmr   <= w_tmr_next;
         if (w_accept) begin
            r_num_pulses <= bus.numPulses;
            r_pulse_idx  <= '0;
            r_error      <= 1'b0;
         end
         if (w_err_enter) r_error <= 1'b1;
         if (w_flush_end) r_pulse_idx <= w_pulse_inc;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_tmr_next   = w_tmr_zero ? r_tmr : r_tmr - 1'b1;
      w_en_coeff   = 1'b0;
      w_en_data    = 1'b0;
      w_en_ht      = 1'b0;
      w_load_data  = 1'b0;
      w_stop_load  = 1'b0;
      w_en_squar   = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_next = LOAD_COEFF;
               w_tmr_next   = TMR_W'(COEFF_TIMEOUT - 1);
            end
         end
         LOAD_COEFF: begin
            w_en_coeff = 1'b1;
            if (bus.coeffSetFlag) begin
               w_state_next = STREAM;
               w_tmr_next   = TMR_W'(DATA_LENGTH - 1);
            end else if (w_tmr_zero) begin
               w_state_next = ERROR;
            end
         end
         STREAM: begin
            w_en_data   = 1'b1;
            w_en_ht     = 1'b1;
            w_load_data = 1'b1;
            w_en_squar  = 1'b1;
            if (w_tmr_zero) begin
               w_state_next = FLUSH;
               w_tmr_next   = TMR_W'(FLUSH_CYCLES - 1);
            end
         end
         FLUSH: begin
            w_en_ht     = 1'b1;
            w_stop_load = 1'b1;
            w_en_squar  = 1'b1;
            if (w_tmr_zero) begin
               if (w_last_pulse) begin
                  w_state_next = DONE;
               end else begin
                  w_state_next = GAP;
                  w_tmr_next   = TMR_W'(GAP_CYCLES - 1);
               end
            end
         end
         GAP: begin
            if (w_tmr_zero) begin
               w_state_next = STREAM;
               w_tmr_next   = TMR_W'(DATA_LENGTH - 1);
            end
         end
         DONE: begin
            w_done       = 1'b1;
            w_state_next = IDLE;
         end
         ERROR: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
      // Cancel wins over every other transition, including a same-cycle start.
      if (bus.abort) begin
         w_state_next = IDLE;
         w_done       = 1'b0;
      end
   end

   pcs_valid_window #(
      .PIPE_LATENCY (PIPE_LATENCY),
      .WINDOW_LENGTH(DATA_LENGTH + COEFF_LENGTH - 1)
   ) u_valid_window (
      .clock  (clock),
      .resetN (resetN),
      .i_start(w_stream_start),
      .i_clear(bus.abort),
      .o_valid(w_win_valid),
      .o_index(w_win_index)
   );

`ifdef PCS_RANGE_GATE_EN
   logic [OUT_INDEX_W-1:0] r_gate_start;
   logic [OUT_INDEX_W-1:0] r_gate_end;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_gate_start <= '0;
         r_gate_end   <= '0;
      end else if (w_accept) begin
         r_gate_start <= bus.gateStart;
         r_gate_end   <= bus.gateEnd;
      end
   end

   assign bus.outValid = w_win_valid && (w_win_index >= r_gate_start) &&
                         (w_win_index <= r_gate_end);
`else
   assign bus.outValid = w_win_valid;
`endif

   assign bus.enableMFCoeff    = w_en_coeff;
   assign bus.loadCoeff        = w_en_coeff;
   assign bus.enableMFDataIn   = w_en_data;
   assign bus.enableHT         = w_en_ht;
   assign bus.loadDataFlag     = w_load_data;
   assign bus.stopDataLoadFlag = w_stop_load;
   assign bus.enableSquar      = w_en_squar;
   assign bus.outIndex         = w_win_index;
   assign bus.pulseIndex       = r_pulse_idx;
   assign bus.busy             = (r_state != IDLE);
   assign bus.done             = w_done;
   assign bus.error            = r_error;

endmodule
